// File: rtl/branch_redirect_ctrl_if.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl_if
//   Bundles the three handshake groups around the redirect controller:
//     - EX branch result   : br_valid, br_jmp_en, br_b_n_jmp, br_target / br_ready
//     - trap request       : trap_req, trap_pc / trap_ack
//     - fetch redirect     : redir_valid, redir_pc / redir_ready
//   slave  : the controller side (consumes results/traps, offers the redirect)
//   master : the surrounding pipeline (EX unit, trap logic, fetch)
// -----------------------------------------------------------------------------
interface branch_redirect_ctrl_if #(
   parameter int XLEN = 32
);
   logic            br_valid;
   logic            br_jmp_en;
   logic            br_b_n_jmp;
   logic [XLEN-1:0] br_target;
   logic            br_ready;

   logic            trap_req;
   logic [XLEN-1:0] trap_pc;
   logic            trap_ack;

   logic            redir_valid;
   logic [XLEN-1:0] redir_pc;
   logic            redir_ready;

   modport slave (
      input  br_valid, br_jmp_en, br_b_n_jmp, br_target,
      input  trap_req, trap_pc,
      input  redir_ready,
      output br_ready, trap_ack,
      output redir_valid, redir_pc
   );

   modport master (
      output br_valid, br_jmp_en, br_b_n_jmp, br_target,
      output trap_req, trap_pc,
      output redir_ready,
      input  br_ready, trap_ack,
      input  redir_valid, redir_pc
   );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// branch_redirect_ctrl
//   Front-end sequencer for resolved control transfers. A taken branch/jump
//   from EX or a trap request (trap wins) starts a FLUSH window of
//   FLUSH_CYCLES cycles, after which the captured target is offered to fetch
//   over a valid/ready handshake. EX is stalled while a redirect is in
//   flight. Taken / not-taken statistics are kept in wrapping counters.
//
// Parameters
//   XLEN         PC width
//   FLUSH_CYCLES cycles flush is held high per redirect (legal 1..15)
//   CNT_W        statistics counter width
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   bus          slave side of branch_redirect_ctrl_if (branch, trap, redirect)
//   flush        squash IF/ID contents
//   ex_stall     hold EX issue while a redirect is outstanding
//   cnt_clr      synchronous clear of both statistics counters
//   taken_cnt    accepted taken transfers (wraps)
//   ntaken_cnt   accepted not-taken conditional branches (wraps)
// -----------------------------------------------------------------------------
module branch_redirect_ctrl #(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   branch_redirect_ctrl_if.slave   bus,
   output logic                    flush,
   output logic                    ex_stall,
   input  logic                    cnt_clr,
   output logic [CNT_W-1:0]        taken_cnt,
   output logic [CNT_W-1:0]        ntaken_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      REDIR = 2'd2
   } state_t;

   // The flush counter holds "cycles remaining after this one", so it is
   // loaded with FLUSH_CYCLES-1 and the window ends when it reads zero.
   localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t          state, state_nxt;
   logic [3:0]      flush_cnt, flush_cnt_nxt;
   logic [XLEN-1:0] redir_pc_q, redir_pc_nxt;
   logic            trap_ack;
   logic            taken_inc;
   logic            ntaken_inc;

   // ---------------------------------------------------------------------------
   // State, flush counter and captured redirect target
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register samples the pre-edge values regardless of process order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         flush_cnt  <= '0;
         redir_pc_q <= '0;
      end else begin
         state      <= state_nxt;
         flush_cnt  <= flush_cnt_nxt;
         redir_pc_q <= redir_pc_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state / transition logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      redir_pc_nxt  = redir_pc_q;
      trap_ack      = 1'b0;
      taken_inc     = 1'b0;
      ntaken_inc    = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.trap_req) begin
               // A branch result in the same cycle is dropped: the trap
               // supersedes whatever EX resolved.
               trap_ack      = 1'b1;
               redir_pc_nxt  = bus.trap_pc;
               flush_cnt_nxt = FLUSH_INIT;
               state_nxt     = FLUSH;
            end else if (bus.br_valid && bus.br_jmp_en) begin
               // Fetch addresses are at least halfword aligned; bit 0 of a
               // computed jalr target is discarded.
               redir_pc_nxt  = {bus.br_target[XLEN-1:1], 1'b0};
               flush_cnt_nxt = FLUSH_INIT;
               taken_inc     = 1'b1;
               state_nxt     = FLUSH;
            end else if (bus.br_valid && bus.br_b_n_jmp) begin
               ntaken_inc    = 1'b1;
            end
         end

         FLUSH: begin
            if (bus.trap_req) begin
               // Late trap replaces the pending target and restarts the
               // flush window so the trap path is squashed in full.
               trap_ack      = 1'b1;
               redir_pc_nxt  = bus.trap_pc;
               flush_cnt_nxt = FLUSH_INIT;
            end else if (flush_cnt == 4'd0) begin
               state_nxt     = REDIR;
            end else begin
               flush_cnt_nxt = flush_cnt - 4'd1;
            end
         end

         REDIR: begin
            // Traps wait here; they are taken from IDLE once fetch has
            // consumed the current redirect.
            if (bus.redir_ready) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign flush           = (state == FLUSH);
   assign ex_stall        = (state != IDLE);
   assign bus.redir_valid = (state == REDIR);
   assign bus.redir_pc    = redir_pc_q;
   assign bus.trap_ack    = trap_ack;
   // A pending trap will win this cycle, so EX must not consider its result
   // consumed.
   assign bus.br_ready    = (state == IDLE) && !bus.trap_req;

   // ---------------------------------------------------------------------------
   // Statistics counters; clear beats increment, both wrap naturally
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         taken_cnt  <= '0;
         ntaken_cnt <= '0;
      end else if (cnt_clr) begin
         taken_cnt  <= '0;
         ntaken_cnt <= '0;
      end else begin
         if (taken_inc) begin
            taken_cnt <= taken_cnt + CNT_ONE;
         end
         if (ntaken_inc) begin
            ntaken_cnt <= ntaken_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_redirect_ctrl
//   Directed bench for branch_redirect_ctrl. The main instance uses the
//   default parameters; a second instance with CNT_W=4 exercises counter
//   wrap. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_branch_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush, ex_stall, cnt_clr;
   logic [31:0] taken_cnt, ntaken_cnt;

   logic        flush4, ex_stall4, cnt_clr4;
   logic [3:0]  taken4, ntaken4;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   branch_redirect_ctrl_if #(.XLEN(32)) bus ();
   branch_redirect_ctrl_if #(.XLEN(32)) bus4 ();

   branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .flush      (flush),
      .ex_stall   (ex_stall),
      .cnt_clr    (cnt_clr),
      .taken_cnt  (taken_cnt),
      .ntaken_cnt (ntaken_cnt)
   );

   branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus4),
      .flush      (flush4),
      .ex_stall   (ex_stall4),
      .cnt_clr    (cnt_clr4),
      .taken_cnt  (taken4),
      .ntaken_cnt (ntaken4)
   );

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.br_valid    = 1'b0; bus.br_jmp_en  = 1'b0; bus.br_b_n_jmp = 1'b0;
      bus.br_target   = '0;   bus.trap_req   = 1'b0; bus.trap_pc    = '0;
      bus.redir_ready = 1'b0; cnt_clr        = 1'b0;
      bus4.br_valid   = 1'b0; bus4.br_jmp_en = 1'b0; bus4.br_b_n_jmp = 1'b0;
      bus4.br_target  = '0;   bus4.trap_req  = 1'b0; bus4.trap_pc    = '0;
      bus4.redir_ready = 1'b0; cnt_clr4      = 1'b0;
   endtask

   // Wait (bounded) for the redirect on the main instance, check its PC,
   // complete the handshake and confirm the return to IDLE.
   task automatic drain(input logic [31:0] exp_pc, input string name);
      int n = 0;
      bus.redir_ready = 1'b1;
      while (bus.redir_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      tests++;
      if (bus.redir_valid !== 1'b1) begin
         fails++;
         $display("FAIL %s_timeout: redir_valid=%b after %0d cycles, want 1", name, bus.redir_valid, n);
      end else if (bus.redir_pc !== exp_pc) begin
         fails++;
         $display("FAIL %s_pc: got %h want %h", name, bus.redir_pc, exp_pc);
      end
      step();
      bus.redir_ready = 1'b0;
      tests++;
      if (ex_stall !== 1'b0) begin
         fails++;
         $display("FAIL %s_idle: ex_stall=%b want 0", name, ex_stall);
      end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      step(); step();
      tests++; if (flush !== 1'b0) begin fails++; $display("FAIL rst_flush: got %b want 0", flush); end
      tests++; if (ex_stall !== 1'b0) begin fails++; $display("FAIL rst_ex_stall: got %b want 0", ex_stall); end
      tests++; if (bus.redir_valid !== 1'b0) begin fails++; $display("FAIL rst_redir_valid: got %b want 0", bus.redir_valid); end
      tests++; if (bus.redir_pc !== 32'h0) begin fails++; $display("FAIL rst_redir_pc: got %h want 0", bus.redir_pc); end
      tests++; if (bus.br_ready !== 1'b1) begin fails++; $display("FAIL rst_br_ready: got %b want 1", bus.br_ready); end
      tests++; if (bus.trap_ack !== 1'b0) begin fails++; $display("FAIL rst_trap_ack: got %b want 0", bus.trap_ack); end
      tests++; if (taken_cnt !== 32'h0 || ntaken_cnt !== 32'h0) begin
         fails++; $display("FAIL rst_cnt: got %h/%h want 0/0", taken_cnt, ntaken_cnt); end
      rst = 1'b1;
      step();
   endtask

   // Taken jump at edge 0: flush cycles 1-2, redirect cycle 3, IDLE cycle 4.
   task automatic test_taken_latency();
      bus.br_valid = 1'b1; bus.br_jmp_en = 1'b1; bus.br_target = 32'h0000_1001;
      bus.redir_ready = 1'b1;
      #1;
      tests++; if (bus.br_ready !== 1'b1) begin fails++; $display("FAIL lat_br_ready: got %b want 1", bus.br_ready); end
      for (int c = 1; c <= 4; c++) begin
         step();
         bus.br_valid = 1'b0; bus.br_jmp_en = 1'b0;
         tests++; if (flush !== (c <= 2)) begin fails++; $display("FAIL lat_flush c%0d: got %b want %b", c, flush, (c <= 2)); end
         tests++; if (ex_stall !== (c <= 3)) begin fails++; $display("FAIL lat_ex_stall c%0d: got %b want %b", c, ex_stall, (c <= 3)); end
         tests++; if (bus.redir_valid !== (c == 3)) begin fails++; $display("FAIL lat_redir_valid c%0d: got %b want %b", c, bus.redir_valid, (c == 3)); end
         if (c == 3) begin
            tests++; if (bus.redir_pc !== 32'h0000_1000) begin fails++; $display("FAIL lat_redir_pc: got %h want 00001000", bus.redir_pc); end
         end
      end
      bus.redir_ready = 1'b0;
      tests++; if (taken_cnt !== 32'd1) begin fails++; $display("FAIL lat_taken_cnt: got %0d want 1", taken_cnt); end
   endtask

   task automatic test_not_taken();
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      tests++; if (taken_cnt !== 32'd0 || ntaken_cnt !== 32'd0) begin
         fails++; $display("FAIL nt_clr: got %0d/%0d want 0/0", taken_cnt, ntaken_cnt); end
      for (int i = 0; i < 3; i++) begin
         bus.br_valid = 1'b1; bus.br_b_n_jmp = 1'b1;
         step();
         bus.br_valid = 1'b0; bus.br_b_n_jmp = 1'b0;
         tests++; if (flush !== 1'b0 || ex_stall !== 1'b0) begin
            fails++; $display("FAIL nt_flush%0d: flush=%b ex_stall=%b want 0/0", i, flush, ex_stall); end
      end
      // Result with neither flag set is ignored.
      bus.br_valid = 1'b1; bus.br_target = 32'h0000_0040;
      step();
      bus.br_valid = 1'b0;
      step();
      tests++; if (ntaken_cnt !== 32'd3) begin fails++; $display("FAIL nt_ntaken_cnt: got %0d want 3", ntaken_cnt); end
      tests++; if (taken_cnt !== 32'd0) begin fails++; $display("FAIL nt_taken_cnt: got %0d want 0", taken_cnt); end
      tests++; if (flush !== 1'b0) begin fails++; $display("FAIL nt_flush_end: got %b want 0", flush); end
   endtask

   task automatic test_trap_priority();
      bus.trap_req = 1'b1; bus.trap_pc = 32'h8000_0000;
      bus.br_valid = 1'b1; bus.br_jmp_en = 1'b1; bus.br_target = 32'h0000_0200;
      #1;
      tests++; if (bus.trap_ack !== 1'b1) begin fails++; $display("FAIL prio_trap_ack: got %b want 1", bus.trap_ack); end
      tests++; if (bus.br_ready !== 1'b0) begin fails++; $display("FAIL prio_br_ready: got %b want 0", bus.br_ready); end
      step();
      bus.trap_req = 1'b0; bus.br_valid = 1'b0; bus.br_jmp_en = 1'b0;
      tests++; if (flush !== 1'b1) begin fails++; $display("FAIL prio_flush: got %b want 1", flush); end
      tests++; if (taken_cnt !== 32'd0) begin fails++; $display("FAIL prio_taken_cnt: got %0d want 0", taken_cnt); end
      drain(32'h8000_0000, "prio");
   endtask

   task automatic test_trap_in_flush();
      bus.br_valid = 1'b1; bus.br_jmp_en = 1'b1; bus.br_target = 32'h0000_0200;
      step();                                     // cycle 1, first FLUSH cycle
      bus.br_valid = 1'b0; bus.br_jmp_en = 1'b0;
      bus.trap_req = 1'b1; bus.trap_pc = 32'h8000_0000;
      #1;
      tests++; if (bus.trap_ack !== 1'b1) begin fails++; $display("FAIL tif_trap_ack: got %b want 1", bus.trap_ack); end
      for (int c = 2; c <= 4; c++) begin
         step();
         bus.trap_req = 1'b0;
         tests++; if (flush !== (c <= 3)) begin fails++; $display("FAIL tif_flush c%0d: got %b want %b", c, flush, (c <= 3)); end
      end
      tests++; if (bus.redir_valid !== 1'b1 || bus.redir_pc !== 32'h8000_0000) begin
         fails++; $display("FAIL tif_redir: valid=%b pc=%h want 1/80000000", bus.redir_valid, bus.redir_pc); end
      tests++; if (taken_cnt !== 32'd1) begin fails++; $display("FAIL tif_taken_cnt: got %0d want 1", taken_cnt); end
      drain(32'h8000_0000, "tif");
   endtask

   // Redirect held for 5 stalled cycles, handshake on the 6th, with a branch
   // and a trap arriving while the redirect is outstanding.
   task automatic test_redir_stall();
      bus.br_valid = 1'b1; bus.br_jmp_en = 1'b1; bus.br_target = 32'h0000_0300;
      step();
      bus.br_valid = 1'b0; bus.br_jmp_en = 1'b0;
      step();                                     // cycle 2
      for (int c = 3; c <= 8; c++) begin
         step();
         bus.br_valid  = (c == 4); bus.br_jmp_en = (c == 4); bus.br_target = 32'h0000_0400;
         bus.trap_req  = (c >= 7); bus.trap_pc   = 32'h0000_0100;
         bus.redir_ready = (c == 8);
         #1;
         tests++; if (bus.redir_valid !== 1'b1 || bus.redir_pc !== 32'h0000_0300 || ex_stall !== 1'b1) begin
            fails++; $display("FAIL stall_hold c%0d: valid=%b pc=%h stall=%b want 1/00000300/1", c, bus.redir_valid, bus.redir_pc, ex_stall); end
         tests++; if (bus.trap_ack !== 1'b0 || bus.br_ready !== 1'b0) begin
            fails++; $display("FAIL stall_ack c%0d: trap_ack=%b br_ready=%b want 0/0", c, bus.trap_ack, bus.br_ready); end
      end
      step();                                     // cycle 9, back in IDLE
      bus.br_valid = 1'b0; bus.br_jmp_en = 1'b0; bus.redir_ready = 1'b0;
      tests++; if (ex_stall !== 1'b0 || bus.redir_valid !== 1'b0) begin
         fails++; $display("FAIL stall_idle: stall=%b valid=%b want 0/0", ex_stall, bus.redir_valid); end
      tests++; if (bus.trap_ack !== 1'b1) begin fails++; $display("FAIL stall_trap_idle: got %b want 1", bus.trap_ack); end
      tests++; if (taken_cnt !== 32'd2) begin fails++; $display("FAIL stall_taken_cnt: got %0d want 2", taken_cnt); end
      step();
      bus.trap_req = 1'b0;
      tests++; if (flush !== 1'b1) begin fails++; $display("FAIL stall_trap_flush: got %b want 1", flush); end
      drain(32'h0000_0100, "stall_trap");
   endtask

   task automatic test_both_flags();
      bus.br_valid = 1'b1; bus.br_jmp_en = 1'b1; bus.br_b_n_jmp = 1'b1; bus.br_target = 32'h0000_0500;
      step();
      bus.br_valid = 1'b0; bus.br_jmp_en = 1'b0; bus.br_b_n_jmp = 1'b0;
      tests++; if (taken_cnt !== 32'd3 || ntaken_cnt !== 32'd3) begin
         fails++; $display("FAIL both_cnt: got %0d/%0d want 3/3", taken_cnt, ntaken_cnt); end
      drain(32'h0000_0500, "both");
   endtask

   task automatic test_cnt_clr_concurrent();
      bus.br_valid = 1'b1; bus.br_jmp_en = 1'b1; bus.br_target = 32'h0000_0600;
      cnt_clr = 1'b1;
      step();
      bus.br_valid = 1'b0; bus.br_jmp_en = 1'b0; cnt_clr = 1'b0;
      tests++; if (taken_cnt !== 32'd0 || ntaken_cnt !== 32'd0) begin
         fails++; $display("FAIL clr_cnt: got %0d/%0d want 0/0", taken_cnt, ntaken_cnt); end
      tests++; if (flush !== 1'b1) begin fails++; $display("FAIL clr_flush: got %b want 1", flush); end
      drain(32'h0000_0600, "clr");
   endtask

   task automatic test_wrap();
      bus4.redir_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         int n = 0;
         bus4.br_valid = 1'b1; bus4.br_jmp_en = 1'b1; bus4.br_target = 32'h0000_0010;
         step();
         bus4.br_valid = 1'b0; bus4.br_jmp_en = 1'b0;
         while (ex_stall4 !== 1'b0 && n < 20) begin
            step();
            n++;
         end
         if (n >= 20) begin
            tests++; fails++; $display("FAIL wrap_timeout%0d: ex_stall4=%b want 0", i, ex_stall4);
         end
         if (i == 15) begin
            tests++; if (taken4 !== 4'hF) begin fails++; $display("FAIL wrap_15: got %h want f", taken4); end
         end
      end
      tests++; if (taken4 !== 4'h0) begin fails++; $display("FAIL wrap_16: got %h want 0", taken4); end
      // Not-taken increment and clear together: clear wins.
      bus4.br_valid = 1'b1; bus4.br_b_n_jmp = 1'b1;
      step();
      tests++; if (ntaken4 !== 4'h1) begin fails++; $display("FAIL wrap_nt: got %h want 1", ntaken4); end
      cnt_clr4 = 1'b1;
      step();
      bus4.br_valid = 1'b0; bus4.br_b_n_jmp = 1'b0; cnt_clr4 = 1'b0;
      tests++; if (ntaken4 !== 4'h0 || taken4 !== 4'h0) begin
         fails++; $display("FAIL wrap_clr: got %h/%h want 0/0", taken4, ntaken4); end
      bus4.redir_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      bus.br_valid = 1'b1; bus.br_jmp_en = 1'b1; bus.br_target = 32'h0000_0700;
      @(posedge clk);
      #2;
      bus.br_valid = 1'b0; bus.br_jmp_en = 1'b0;
      tests++; if (flush !== 1'b1) begin fails++; $display("FAIL arst_pre_flush: got %b want 1", flush); end
      rst = 1'b0;
      #1;
      tests++; if (flush !== 1'b0 || ex_stall !== 1'b0 || bus.redir_valid !== 1'b0) begin
         fails++; $display("FAIL arst_ctrl: flush=%b stall=%b valid=%b want 0/0/0", flush, ex_stall, bus.redir_valid); end
      tests++; if (bus.br_ready !== 1'b1 || bus.redir_pc !== 32'h0) begin
         fails++; $display("FAIL arst_ready_pc: br_ready=%b pc=%h want 1/0", bus.br_ready, bus.redir_pc); end
      tests++; if (taken_cnt !== 32'h0 || ntaken_cnt !== 32'h0) begin
         fails++; $display("FAIL arst_cnt: got %0d/%0d want 0/0", taken_cnt, ntaken_cnt); end
      step();
      rst = 1'b1;
      step();
      tests++; if (ex_stall !== 1'b0 || flush !== 1'b0) begin
         fails++; $display("FAIL arst_after: stall=%b flush=%b want 0/0", ex_stall, flush); end
   endtask

   initial begin
      test_reset();
      test_taken_latency();
      test_not_taken();
      test_trap_priority();
      test_trap_in_flush();
      test_redir_stall();
      test_both_flags();
      test_cnt_clr_concurrent();
      test_wrap();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences the front-end response to resolved control transfers.
- Accepts resolved branch/jump results from the EX branch unit and trap requests from the CSR/trap logic, with trap taking priority.
- Drives a timed pipeline flush, then offers a single redirect PC to instruction fetch over a valid/ready handshake.
- Stalls EX while a redirect is outstanding and keeps taken/not-taken branch statistics.

Parameters:
- XLEN, 32, data/PC width.
- FLUSH_CYCLES, 2, cycles `flush` is held high per redirect; legal range 1..15.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- br_valid  in  1  EX branch result valid this cycle.
- br_jmp_en  in  1  resolved transfer taken (branch taken, jal, jalr).
- br_b_n_jmp  in  1  conditional branch resolved not-taken.
- br_target  in  XLEN  resolved target PC.
- br_ready  out  1  controller can accept a branch result.
- trap_req  in  1  trap/interrupt redirect request; held until acknowledged.
- trap_pc  in  XLEN  trap vector PC.
- trap_ack  out  1  trap accepted this cycle.
- flush  out  1  squash IF/ID contents.
- ex_stall  out  1  hold EX issue.
- redir_valid  out  1  redirect PC offered to fetch.
- redir_pc  out  XLEN  redirect target.
- redir_ready  in  1  fetch accepts redirect.
- cnt_clr  in  1  synchronous clear of the statistics counters.
- taken_cnt  out  CNT_W  count of accepted taken transfers.
- ntaken_cnt  out  CNT_W  count of accepted not-taken branches.

Behaviour:
- Reset (rst=0, async): state=IDLE, flush_cnt=0, redir_pc=0, taken_cnt=0, ntaken_cnt=0. All control outputs are 0 except br_ready=1.
- States: IDLE, FLUSH, REDIR. All outputs are Moore except trap_ack and br_ready, which are combinational from state and inputs.
- br_ready = (state==IDLE) & ~trap_req.
- ex_stall = (state!=IDLE).
- flush = (state==FLUSH).
- redir_valid = (state==REDIR).
- IDLE, priority order:
  - trap_req: trap_ack=1, redir_pc<=trap_pc, flush_cnt<=FLUSH_CYCLES-1, go FLUSH. Any simultaneous br_valid is discarded and not counted.
  - br_valid & br_jmp_en: redir_pc<=br_target with bit0 forced 0, taken_cnt++, flush_cnt<=FLUSH_CYCLES-1, go FLUSH. br_jmp_en wins if br_b_n_jmp is also set.
  - br_valid & br_b_n_jmp & ~br_jmp_en: ntaken_cnt++, stay IDLE.
  - br_valid with neither flag: ignored, stay IDLE.
- FLUSH:
  - flush_cnt==0: go REDIR; otherwise flush_cnt--.
  - trap_req in FLUSH: trap_ack=1, redir_pc<=trap_pc, flush_cnt<=FLUSH_CYCLES-1, stay FLUSH. The flush window restarts.
- REDIR:
  - redir_pc is held stable while redir_valid=1 and redir_ready=0.
  - redir_valid & redir_ready: go IDLE.
  - trap_req is not accepted in REDIR (trap_ack=0). The trap is taken in IDLE on the following cycle.
- br_valid outside IDLE: ignored, not counted. EX must honour ex_stall.
- Latency: a result accepted at edge N gives flush=1 for cycles N+1..N+FLUSH_CYCLES. redir_valid rises at N+FLUSH_CYCLES+1. With redir_ready=1, the controller is back in IDLE after edge N+FLUSH_CYCLES+1.
- Counters:
  - Wrap modulo 2^CNT_W.
  - cnt_clr has priority over an increment in the same cycle; both counters read 0 next cycle.
- Mid-operation reset: aborts immediately to reset values; a pending redirect is lost.

Test Plan:
- Reset, FLUSH_CYCLES=2: br_valid=1, br_jmp_en=1, br_target=0x0000_1001 at edge 0 -> flush=1 cycles 1-2. redir_valid=1, redir_pc=0x0000_1000 at cycle 3. With redir_ready=1, IDLE at cycle 4. taken_cnt=1, ex_stall=1 cycles 1-3.
- Three br_valid+br_b_n_jmp pulses in IDLE -> ntaken_cnt=3, taken_cnt=0, flush never asserted.
- trap_req (trap_pc=0x8000_0000) and taken branch (target 0x200) in the same IDLE cycle -> trap_ack=1, redir_pc=0x8000_0000, taken_cnt unchanged.
- Taken branch to 0x200, then trap_req at the first FLUSH cycle -> trap_ack=1, flush stays high 2 further cycles, redir_pc=0x8000_0000.
- REDIR with redir_ready=0 for 5 cycles -> redir_valid and redir_pc (0x300) stable, ex_stall=1. Taken branch presented meanwhile is not counted. Handshake on cycle 6 -> IDLE.
- taken_cnt preloaded to 0xFFFF_FFFF via 2^32-1 events is infeasible; instead use CNT_W=4: 16 taken branches -> taken_cnt=0. cnt_clr concurrent with an increment -> 0. Assert rst mid-FLUSH -> all outputs at reset values the same cycle.
